// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared constants, loader state type and parity helper
// Purpose: common definitions for the instruction ROM responder slice.
// Optional feature macro: INSTR_ROM_PARITY_EN (uses even_parity below).
package cpu_mem_pkg;

  localparam int ADDR_W         = 5;
  localparam int DATA_W         = 32;
  localparam int DEPTH          = 1 << ADDR_W;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  // Parity bit that makes the total number of ones (word + bit) even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/instr_rom_responder_if.sv
// rtl/instr_rom_responder_if.sv - fetch and byte-loader bus of the instruction ROM
// Purpose: groups the fetch request/response and loader signals.
//   master: fetch path + boot loader (drives rom_address, rd_en, load_start,
//           load_byte, load_byte_valid)
//   slave : instr_rom_responder (drives instruction, instr_valid, load_ready,
//           load_busy, load_done and, with INSTR_ROM_PARITY_EN, parity_err)
interface instr_rom_responder_if;
  import cpu_mem_pkg::*;

  logic [ADDR_W-1:0] rom_address;
  logic              rd_en;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              load_start;
  logic [7:0]        load_byte;
  logic              load_byte_valid;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
`ifdef INSTR_ROM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output rom_address, rd_en, load_start, load_byte, load_byte_valid,
`ifdef INSTR_ROM_PARITY_EN
    input  parity_err,
`endif
    input  instruction, instr_valid, load_ready, load_busy, load_done
  );

  modport slave (
    input  rom_address, rd_en, load_start, load_byte, load_byte_valid,
`ifdef INSTR_ROM_PARITY_EN
    output parity_err,
`endif
    output instruction, instr_valid, load_ready, load_busy, load_done
  );

endinterface

// File: rtl/rom_byte_assembler.sv
// rtl/rom_byte_assembler.sv - little-endian byte-to-word assembler for the ROM loader
// Purpose: counts accepted bytes, holds bytes 0..2 and presents the full word
//          together with a one-cycle strobe when byte 3 is accepted.
// Ports: clk, reset (async, active-high), clear (restart at byte 0),
//        accept (byte transfer this cycle), byte_in, word, word_done.
module rom_byte_assembler
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  logic [1:0]  bcnt;
  logic [23:0] hold;

  // Byte 3 is taken straight from the input so the word is ready in the
  // same cycle it completes.
  assign word      = {byte_in, hold};
  assign word_done = accept && (bcnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt <= 2'd0;
      hold <= 24'd0;
    end else if (clear) begin
      bcnt <= 2'd0;
    end else if (accept) begin
      bcnt <= bcnt + 2'd1;
      case (bcnt)
        2'd0:    hold[7:0]   <= byte_in;
        2'd1:    hold[15:8]  <= byte_in;
        2'd2:    hold[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_rom_responder.sv
// rtl/instr_rom_responder.sv - boot-loadable instruction memory with 1-cycle fetch
// Purpose: 2**ADDR_W x DATA_W instruction memory. Fetches in IDLE return
//          mem[rom_address] one cycle later; a byte-serial load fills the whole
//          image from word 0 and blocks fetches (NOP, invalid) while active.
// Ports: clk, reset (async, active-high), bus (instr_rom_responder_if.slave).
// Optional macro INSTR_ROM_PARITY_EN: per-word even parity and parity_err.
module instr_rom_responder
  import cpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  instr_rom_responder_if.slave  bus
);

  load_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic              done_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic [DATA_W-1:0] asm_word;
  logic              word_done;
  logic              accept;
  logic              start;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state == LOAD) && bus.load_byte_valid;
  assign start  = (state == IDLE) && bus.load_start;

  rom_byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .accept    (accept),
    .byte_in   (bus.load_byte),
    .word      (asm_word),
    .word_done (word_done)
  );

  // Loader FSM. The last word is written on the same edge that returns to
  // IDLE, so the first IDLE fetch already sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.load_start) begin
          state  <= LOAD;
          ptr    <= '0;
          done_q <= 1'b0;
        end
        LOAD: if (word_done) begin
          ptr <= ptr + 1'b1;
          if (&ptr) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (word_done) mem[ptr] <= asm_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (state == LOAD) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (bus.rd_en) begin
      instr_q <= mem[bus.rom_address];
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

`ifdef INSTR_ROM_PARITY_EN
  logic mem_par [DEPTH];
  logic perr_q;

  always_ff @(posedge clk) begin
    if (word_done) mem_par[ptr] <= even_parity(asm_word);
  end

  // Error only accompanies a valid fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perr_q <= 1'b0;
    else if ((state == IDLE) && bus.rd_en)
      perr_q <= even_parity(mem[bus.rom_address]) ^ mem_par[bus.rom_address];
    else
      perr_q <= 1'b0;
  end

  assign bus.parity_err = perr_q;
`endif

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.load_ready  = (state == LOAD);
  assign bus.load_busy   = (state == LOAD);
  assign bus.load_done   = done_q;

endmodule

// File: tb/tb_instr_rom_responder.sv
// tb/tb_instr_rom_responder.sv - self-checking bench for instr_rom_responder
module tb_instr_rom_responder;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_rom_responder_if bus ();

  instr_rom_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: image contents plus a running count of accepted bytes.
  logic [31:0] m_mem   [32];
  bit          m_known [32];
  bit          m_flip  [32];
  bit          m_busy, m_done, m_valid, m_inst_known, m_perr;
  logic [31:0] m_inst, m_hold;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
    check("busy", {31'd0, bus.load_busy}, {31'd0, m_busy});
    check("ready", {31'd0, bus.load_ready}, {31'd0, m_busy});
    check("done", {31'd0, bus.load_done}, {31'd0, m_done});
    if (m_inst_known) check("instr", bus.instruction, m_inst);
`ifdef INSTR_ROM_PARITY_EN
    check("perr", {31'd0, bus.parity_err}, {31'd0, m_perr});
`endif
  endtask

  task automatic step(input logic rd, input logic [4:0] a, input logic ls,
                      input logic bv, input logic [7:0] b);
    bus.rd_en = rd; bus.rom_address = a; bus.load_start = ls;
    bus.load_byte_valid = bv; bus.load_byte = b;
    @(posedge clk);
    if (!m_busy) begin
      if (rd) begin
        m_valid = 1; m_inst = m_mem[a]; m_inst_known = m_known[a]; m_perr = m_flip[a];
      end else begin
        m_valid = 0; m_perr = 0;
      end
      if (ls) begin m_busy = 1; m_cnt = 0; m_done = 0; end
    end else begin
      m_valid = 0; m_inst = NOP_WORD; m_inst_known = 1; m_perr = 0;
      if (bv) begin
        m_hold[(m_cnt % 4) * 8 +: 8] = b;
        m_cnt++;
        if (m_cnt % 4 == 0) begin
          m_mem[m_cnt / 4 - 1] = m_hold;
          m_known[m_cnt / 4 - 1] = 1;
          m_flip[m_cnt / 4 - 1] = 0;
        end
        if (m_cnt == 128) begin m_busy = 0; m_done = 1; end
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bus.rd_en = 0; bus.load_start = 0; bus.load_byte_valid = 0;
    reset = 1'b1;
    m_busy = 0; m_done = 0; m_valid = 0; m_inst = NOP_WORD; m_inst_known = 1; m_perr = 0;
    #1;
    check("rst_instr", bus.instruction, NOP_WORD);
    check_model();
    @(posedge clk);
    #1;
    check_model();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w, input int nbytes, input bit gaps);
    for (int k = 0; k < nbytes; k++) begin
      if (gaps) begin
        int ng;
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) step(1, 0, 0, 0, 8'h00);
      end
      step(1, 0, 0, 1, w[8 * k +: 8]);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [4:0]  a;
    logic        ls;
    logic        bv;
    logic [7:0]  b;
    logic        ev;
    logic [31:0] ei;
    logic        eb;
    logic        ed;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 32; i++) begin m_known[i] = 0; m_flip[i] = 0; m_mem[i] = '0; end
    m_cnt = 0; m_hold = '0;
    bus.rom_address = '0; bus.load_byte = '0;

    // Reset state
    do_reset();

    // Full image load, word i = A000_0000 + i, fetch attempts blocked throughout
    step(1, 5'd3, 1, 0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      load_word(32'hA000_0000 + i, 4, i[0]);
      if (i < 31) begin
        check("load_blk_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("load_blk_instr", bus.instruction, NOP_WORD);
      end
    end
    check("full_done", {31'd0, bus.load_done}, 32'd1);
    check("full_busy", {31'd0, bus.load_busy}, 32'd0);
    step(1, 5'd31, 0, 0, 8'h00);
    check("fetch31", bus.instruction, 32'hA000_001F);
    step(0, 5'd7, 0, 0, 8'h00);
    check("hold_instr", bus.instruction, 32'hA000_001F);
    check("hold_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Reset then fetch: memory survives reset
    do_reset();
    step(1, 5'd3, 0, 0, 8'h00);
    check("rst_fetch3", bus.instruction, 32'hA000_0003);
    check("rst_fetch3_v", {31'd0, bus.instr_valid}, 32'd1);

    // Table: fetch+load_start collision, then byte gaps during word 0
    tbl[0] = '{1, 5'd3, 1, 0, 8'h00, 1, 32'hA000_0003, 1, 0};
    tbl[1] = '{1, 5'd0, 0, 1, 8'h78, 0, 32'h0, 1, 0};
    tbl[2] = '{1, 5'd0, 1, 0, 8'h00, 0, 32'h0, 1, 0};
    tbl[3] = '{1, 5'd0, 0, 1, 8'h56, 0, 32'h0, 1, 0};
    tbl[4] = '{0, 5'd0, 0, 0, 8'h99, 0, 32'h0, 1, 0};
    tbl[5] = '{1, 5'd0, 0, 1, 8'h34, 0, 32'h0, 1, 0};
    tbl[6] = '{1, 5'd0, 0, 0, 8'h00, 0, 32'h0, 1, 0};
    tbl[7] = '{1, 5'd0, 0, 1, 8'h12, 0, 32'h0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rd, tbl[i].a, tbl[i].ls, tbl[i].bv, tbl[i].b);
      check("tbl_valid", {31'd0, bus.instr_valid}, {31'd0, tbl[i].ev});
      check("tbl_instr", bus.instruction, tbl[i].ei);
      check("tbl_ready", {31'd0, bus.load_ready}, {31'd0, tbl[i].eb});
      check("tbl_done", {31'd0, bus.load_done}, {31'd0, tbl[i].ed});
    end
    do_reset();
    step(1, 5'd0, 0, 0, 8'h00);
    check("gap_word", bus.instruction, 32'h1234_5678);
    step(1, 5'd1, 0, 0, 8'h00);
    check("gap_word1", bus.instruction, 32'hA000_0001);

    // Reset after two bytes of word 5
    step(0, 5'd0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) load_word(32'hB000_0000 + i, 4, 1);
    load_word(32'hB000_0005, 2, 1);
    do_reset();
    check("midrst_done", {31'd0, bus.load_done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, i[4:0], 0, 0, 8'h00);
      check("midrst_mem", bus.instruction, (i < 5) ? 32'hB000_0000 + i : 32'hA000_0005);
    end

`ifdef INSTR_ROM_PARITY_EN
    step(0, 5'd0, 1, 0, 8'h00);
    load_word(32'h0000_0001, 4, 0);
    do_reset();
    step(1, 5'd0, 0, 0, 8'h00);
    check("par_ok", {31'd0, bus.parity_err}, 32'd0);
    dut.mem[0] = 32'h0000_0003;
    m_mem[0] = 32'h0000_0003;
    m_flip[0] = 1;
    step(1, 5'd0, 0, 0, 8'h00);
    check("par_err", {31'd0, bus.parity_err}, 32'd1);
    check("par_err_v", {31'd0, bus.instr_valid}, 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 899) == 0)
        do_reset();
      else
        step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
